// File: rtl/pico_mul_pkg.sv
// ============================================================================
// Module  : pico_mul_pkg
// Brief   : Shared widths, iteration count, N2 limits and FSM encoding for the
//           PicoMul sequential approximate multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pico_mul_pkg;

    localparam int OPW    = 4;
    localparam int PRODW  = 8;
    localparam int ITERS  = 4;
    localparam int N2_MIN = 0;
    localparam int N2_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/x4_approx_add.sv
// ============================================================================
// Module  : x4_approx_add
// Brief   : 4-bit lower-part-OR approximate adder. The N2 LSBs are OR-ed; the
//           AND of the top approximate bit pair carries into the exact part.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module x4_approx_add #(
    parameter int N2 = 0
) (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin_4bit,
    output logic [3:0] sum,
    output logic       cout_4bit
);

    // Carry-in only reaches the exact path; approximate modes drop it.
    logic w_unused_cin;
    assign w_unused_cin = cin_4bit;

    generate
        if (N2 == 0) begin : g_exact
            assign {cout_4bit, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin_4bit};
        end else if (N2 >= 4) begin : g_all_approx
            assign sum       = a | b;
            assign cout_4bit = a[3] & b[3];
        end else begin : g_split
            logic w_carry;
            assign w_carry          = a[N2-1] & b[N2-1];
            assign sum[N2-1:0]      = a[N2-1:0] | b[N2-1:0];
            assign {cout_4bit, sum[3:N2]} = {1'b0, a[3:N2]} + {1'b0, b[3:N2]}
                                          + {{(4-N2){1'b0}}, w_carry};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/seq_approx_mul4.sv
// ============================================================================
// Module  : seq_approx_mul4
// Brief   : Sequential 4x4 shift-and-add multiplier, one add per cycle through
//           x4_approx_add, valid/ready handshake on both sides.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_approx_mul4
    import pico_mul_pkg::*;
#(
    parameter int N2 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PRODW-1:0] product
);

    generate
        if ((N2 < N2_MIN) || (N2 > N2_MAX)) begin : g_n2_range
            $error("seq_approx_mul4: N2 out of range");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [OPW-1:0]   mcand_q, mcand_d;
    logic [OPW-1:0]   acc_hi_q, acc_hi_d;
    logic [OPW-1:0]   acc_lo_q, acc_lo_d;
    logic [1:0]       cnt_q, cnt_d;

    logic [OPW-1:0]   w_addend;
    logic [OPW-1:0]   w_sum;
    logic             w_cout;

    assign w_addend = acc_lo_q[0] ? mcand_q : '0;

    x4_approx_add #(
        .N2 (N2)
    ) u_add (
        .a         (acc_hi_q),
        .b         (w_addend),
        .cin_4bit  (1'b0),
        .sum       (w_sum),
        .cout_4bit (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Right shift of the 9-bit {cout, sum, acc_lo}.
                {acc_hi_d, acc_lo_d} = {w_cout, w_sum, acc_lo_q[OPW-1:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(ITERS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = {acc_hi_q, acc_lo_q};

endmodule

`default_nettype wire
